// File: rtl/game_ctrl.sv
// Game sequencer for the gravity-flip runner: button conditioning, IDLE/READY/RUN/OVER control,
// flip-request latching, death detection and score keeping.
module game_ctrl #(
   parameter int unsigned ScreenHeight     = 480,
   parameter int unsigned DebounceCycles   = 1000000,
   parameter int unsigned StartDelayFrames = 60,
   parameter int unsigned ScoreWidth       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  btn_start_i,
   input  logic                  btn_flip_i,
   input  logic                  tick_i,
   input  logic [8:0]            luc_loc_i,
   output logic                  player_en_o,
   output logic                  restart_game_o,
   output logic                  grv_o,
   output logic                  scroll_en_o,
   output logic [1:0]            state_o,
   output logic [ScoreWidth-1:0] score_o,
   output logic [ScoreWidth-1:0] hiscore_o
);

   localparam int unsigned DbW  = (DebounceCycles > 1) ? $clog2(DebounceCycles + 1) : 1;
   localparam int unsigned FrmW = (StartDelayFrames > 1) ? $clog2(StartDelayFrames + 1) : 1;
   localparam logic [DbW-1:0]  DbLast  = DbW'(DebounceCycles - 1);
   localparam logic [FrmW-1:0] FrmLoad = FrmW'(StartDelayFrames);
   localparam logic [FrmW-1:0] FrmOne  = FrmW'(1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReady = 2'd1,
      StRun   = 2'd2,
      StOver  = 2'd3
   } state_e;

   logic [1:0] btn_raw;
   logic [1:0] press;

   assign btn_raw = {btn_flip_i, btn_start_i};

   // Bit 0 is the start button, bit 1 the flip button; both share one conditioning path.
   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic           sync1_q;
      logic           sync2_q;
      logic           level_q;
      logic           event_q;
      logic [DbW-1:0] cnt_q;

      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            event_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= btn_raw[b];
            sync2_q <= sync1_q;
            event_q <= 1'b0;
            if (sync2_q != level_q) begin
               if (cnt_q == DbLast) begin
                  level_q <= sync2_q;
                  event_q <= sync2_q;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end else begin
               cnt_q <= '0;
            end
         end
      end

      assign press[b] = event_q;
   end

   state_e                state_q;
   logic [FrmW-1:0]       frm_q;
   logic                  run_q;
   logic                  restart_q;
   logic                  grv_q;
   logic                  dead_q;
   logic [ScoreWidth-1:0] score_q;
   logic [ScoreWidth-1:0] hiscore_q;

   // Off-screen compare also catches a 9-bit underflow wrapping to 511.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         dead_q <= 1'b0;
      end else begin
         dead_q <= (32'(luc_loc_i) >= ScreenHeight);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= StIdle;
         frm_q     <= '0;
         run_q     <= 1'b0;
         restart_q <= 1'b0;
         grv_q     <= 1'b0;
         score_q   <= '0;
         hiscore_q <= '0;
      end else begin
         restart_q <= 1'b0;
         case (state_q)
            StIdle, StOver: begin
               if (press[0]) begin
                  state_q   <= StReady;
                  restart_q <= 1'b1;
                  frm_q     <= FrmLoad;
                  score_q   <= '0;
               end
            end
            StReady: begin
               if (tick_i) begin
                  if (frm_q == FrmOne) begin
                     state_q <= StRun;
                     run_q   <= 1'b1;
                  end else begin
                     frm_q <= frm_q - 1'b1;
                  end
               end
            end
            StRun: begin
               if (dead_q) begin
                  state_q <= StOver;
                  run_q   <= 1'b0;
                  grv_q   <= 1'b0;
                  if (score_q > hiscore_q) begin
                     hiscore_q <= score_q;
                  end
               end else begin
                  if (tick_i && (score_q != '1)) begin
                     score_q <= score_q + 1'b1;
                  end
                  // A new request outranks the clearing tick so it survives one full frame.
                  if (press[1]) begin
                     grv_q <= 1'b1;
                  end else if (tick_i) begin
                     grv_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign state_o        = state_q;
   assign player_en_o    = run_q;
   assign scroll_en_o    = run_q;
   assign restart_game_o = restart_q;
   assign grv_o          = grv_q;
   assign score_o        = score_q;
   assign hiscore_o      = hiscore_q;

endmodule
